// File: rtl/flash_fetch_seq_if.sv
// -----------------------------------------------------------------------------
// flash_fetch_seq_if
// Bundles the job, flash-controller and packed-word stream signals of the
// flash fetch sequencer.
//   job    : start, base_addr, word_count -> busy, done, error
//   flash  : fmc_req, fmc_addr -> fmc_data, fmc_data_valid
//   stream : word_out, word_valid -> word_ready
// Modports:
//   slave  : the sequencer itself (receives jobs, drives flash requests and
//            the packed-word stream)
//   master : the surrounding system (network FSM, flash controller, consumer)
// -----------------------------------------------------------------------------
interface flash_fetch_seq_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       word_count;
    logic              busy;
    logic              done;
    logic              error;
    logic              fmc_req;
    logic [ADDR_W-1:0] fmc_addr;
    logic [7:0]        fmc_data;
    logic              fmc_data_valid;
    logic [31:0]       word_out;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output start, base_addr, word_count, fmc_data, fmc_data_valid, word_ready,
        input  busy, done, error, fmc_req, fmc_addr, word_out, word_valid
    );

    modport slave (
        input  start, base_addr, word_count, fmc_data, fmc_data_valid, word_ready,
        output busy, done, error, fmc_req, fmc_addr, word_out, word_valid
    );
endinterface

// File: rtl/flash_fetch_seq.sv
// -----------------------------------------------------------------------------
// flash_fetch_seq
// Turns a (base address, word count) job into single-byte flash reads with one
// read outstanding, packs every 4 returned bytes little-endian into a 32-bit
// word, and buffers the words in a small FIFO drained by a valid/ready
// consumer. A read that is not answered within TIMEOUT cycles aborts the job
// and raises a sticky error.
// Ports:
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : flash_fetch_seq_if.slave (job, flash request and word stream)
// -----------------------------------------------------------------------------
module flash_fetch_seq #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 31
) (
    input  logic                 clk,
    input  logic                 n_rst,
    flash_fetch_seq_if.slave     bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_DATA, S_HOLD, S_DRAIN, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;        // lower three lanes of the word in assembly
    logic [15:0]       remaining_q, remaining_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic              fifo_full, fifo_empty;
    logic              push, pop, flush;
    logic              fmc_req;
    logic [31:0]       push_word;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus.word_ready;
    // The fourth byte goes straight into the FIFO alongside the held lanes.
    assign push_word  = {bus.fmc_data, word_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        remaining_d = remaining_q;
        tcnt_d      = tcnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        push        = 1'b0;
        flush       = 1'b0;
        fmc_req     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    error_d = 1'b0;
                    if (bus.word_count != 16'd0) begin
                        addr_d      = bus.base_addr;
                        remaining_d = bus.word_count;
                        byte_idx_d  = '0;
                        busy_d      = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // A new word is only begun when the FIFO can take it.
                if (byte_idx_q == 2'd0 && fifo_full) begin
                    state_d = S_HOLD;
                end else begin
                    fmc_req = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_WAIT_DATA;
                end
            end
            S_HOLD: begin
                if (!fifo_full) state_d = S_ISSUE;
            end
            S_WAIT_DATA: begin
                if (bus.fmc_data_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (byte_idx_q == 2'd3) begin
                        push        = 1'b1;
                        byte_idx_d  = '0;
                        remaining_d = remaining_q - 16'd1;
                        state_d     = (remaining_q == 16'd1) ? S_DRAIN : S_ISSUE;
                    end else begin
                        case (byte_idx_q)
                            2'd0:    word_d[7:0]   = bus.fmc_data;
                            2'd1:    word_d[15:8]  = bus.fmc_data;
                            default: word_d[23:16] = bus.fmc_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_ISSUE;
                    end
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                flush      = 1'b1;
                busy_d     = 1'b0;
                error_d    = 1'b1;
                byte_idx_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            remaining_q <= '0;
            tcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            remaining_q <= remaining_d;
            tcnt_q      <= tcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.fmc_req    = fmc_req;
    assign bus.fmc_addr   = addr_q;
    assign bus.word_valid = !fifo_empty;
    assign bus.word_out   = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_flash_fetch_seq.sv
module tb_flash_fetch_seq;
    localparam int unsigned AW = 20;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    flash_fetch_seq_if #(.ADDR_W(AW)) bus();

    flash_fetch_seq #(.ADDR_W(AW), .FIFO_DEPTH(4), .TIMEOUT(31)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]    flash [logic [AW-1:0]];
    logic [AW-1:0] exp_addr [$];
    logic [31:0]   exp_words [$];
    int            req_total = 0;
    int            done_cnt = 0;
    int            resp_seen = 0;
    int            drop_at = 0;     // 0: answer every request
    int            resp_delay = 3;  // 0: random 1..5
    int            gen = 0;
    bit            ready_rand = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [AW-1:0] a);
        if (flash.exists(a)) return flash[a];
        return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'hA5;
    endfunction

    // Reference model: a job reads bytes base..base+4*wc-1 (mod 2^AW),
    // each group of four forming one little-endian word.
    task automatic expect_job(input logic [AW-1:0] base, input int wc);
        logic [AW-1:0] a;
        logic [31:0]   w;
        a = base;
        for (int k = 0; k < wc; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                w = w | (32'(fbyte(a)) << (8 * j));
                exp_addr.push_back(a);
                a = a + 1'b1;
            end
            exp_words.push_back(w);
        end
    endtask

    // Monitors: word scoreboard, request address scoreboard, done counter.
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.word_valid && bus.word_ready) begin
                if (exp_words.size() == 0) chk("unexpected_word", {32'h0, bus.word_out}, 64'hDEAD);
                else chk("word", {32'h0, bus.word_out}, {32'h0, exp_words.pop_front()});
            end
            if (bus.fmc_req) begin
                req_total++;
                if (exp_addr.size() == 0) chk("unexpected_req", 64'(bus.fmc_addr), 64'hDEAD);
                else chk("req_addr", 64'(bus.fmc_addr), 64'(exp_addr.pop_front()));
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_words_left", 64'(exp_words.size()), 64'd0);
            end
        end
    end

    // Flash controller model: one response per request after a delay.
    initial begin
        logic [AW-1:0] a;
        int g, d;
        bus.fmc_data_valid = 1'b0;
        bus.fmc_data = '0;
        forever begin
            @(negedge clk);
            if (n_rst && bus.fmc_req) begin
                a = bus.fmc_addr;
                g = gen;
                resp_seen++;
                if (drop_at == 0 || resp_seen < drop_at) begin
                    d = (resp_delay == 0) ? int'($urandom_range(1, 5)) : resp_delay;
                    repeat (d) @(posedge clk);
                    #1;
                    if (g == gen && n_rst) begin
                        chk("addr_stable", 64'(bus.fmc_addr), 64'(a));
                        bus.fmc_data_valid = 1'b1;
                        bus.fmc_data = fbyte(a);
                        @(posedge clk);
                        #1 bus.fmc_data_valid = 1'b0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_rand) bus.word_ready = 1'($urandom_range(0, 1));
    end

    task automatic pulse_start(input logic [AW-1:0] base, input int wc);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.word_count = 16'(wc);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_cnt > d0) break;
        end
        repeat (3) @(negedge clk);
        chk("done_once", 64'(done_cnt), 64'(d0 + 1));
        chk("words_left", 64'(exp_words.size()), 64'd0);
        chk("addrs_left", 64'(exp_addr.size()), 64'd0);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic wait_resp(input int n, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (resp_seen >= n) break;
        end
        if (i == bound) chk("resp_timeout", 64'(resp_seen), 64'(n));
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int wc);
        int d0;
        d0 = done_cnt;
        resp_seen = 0;
        expect_job(base, wc);
        pulse_start(base, wc);
        wait_done(d0, 400 * wc + 50);
    endtask

    initial begin
        int d0, r0;
        logic [AW-1:0] a0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.word_ready = 1'b0;
        for (int i = 0; i < 8; i++) flash[AW'(20'h00100 + i)] = 8'(8'h11 * (i + 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_req", 64'(bus.fmc_req), 64'd0);
        chk("rst_addr", 64'(bus.fmc_addr), 64'd0);
        chk("rst_wvalid", 64'(bus.word_valid), 64'd0);
        chk("rst_wout", 64'(bus.word_out), 64'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        // Basic job, with start-to-request latency check.
        bus.word_ready = 1'b1;
        d0 = done_cnt;
        resp_seen = 0;
        expect_job(20'h00100, 2);
        chk("basic_w0_model", 64'(exp_words[0]), 64'h44332211);
        chk("basic_w1_model", 64'(exp_words[1]), 64'h88776655);
        pulse_start(20'h00100, 2);
        @(negedge clk);
        chk("first_req_latency", 64'(bus.fmc_req), 64'd1);
        chk("busy_on_start", 64'(bus.busy), 64'd1);
        wait_done(d0, 400);

        // Backpressure.
        bus.word_ready = 1'b0;
        d0 = done_cnt;
        resp_seen = 0;
        r0 = req_total;
        expect_job(20'h2A5C0, 6);
        pulse_start(20'h2A5C0, 6);
        wait_resp(16, 300);
        repeat (30) @(negedge clk);
        chk("bp_reqs_stall1", 64'(req_total - r0), 64'd16);
        chk("bp_busy", 64'(bus.busy), 64'd1);
        chk("bp_wvalid", 64'(bus.word_valid), 64'd1);
        @(posedge clk);
        #1 bus.word_ready = 1'b1;
        @(posedge clk);
        #1 bus.word_ready = 1'b0;
        repeat (60) @(negedge clk);
        chk("bp_reqs_stall2", 64'(req_total - r0), 64'd20);
        bus.word_ready = 1'b1;
        wait_done(d0, 400);
        chk("bp_reqs_total", 64'(req_total - r0), 64'd24);

        // Timeout on the second request.
        d0 = done_cnt;
        resp_seen = 0;
        drop_at = 2;
        expect_job(20'h01230, 2);
        pulse_start(20'h01230, 2);
        wait_resp(2, 100);
        repeat (28) @(negedge clk);
        chk("to_not_early", 64'(bus.error), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.error) break;
        end
        chk("to_error", 64'(bus.error), 64'd1);
        chk("to_busy", 64'(bus.busy), 64'd0);
        chk("to_wvalid", 64'(bus.word_valid), 64'd0);
        repeat (5) @(negedge clk);
        chk("to_no_done", 64'(done_cnt), 64'(d0));
        chk("to_error_sticky", 64'(bus.error), 64'd1);
        exp_words.delete();
        exp_addr.delete();
        drop_at = 0;
        d0 = done_cnt;
        resp_seen = 0;
        expect_job(20'h01230, 2);
        pulse_start(20'h01230, 2);
        @(negedge clk);
        chk("error_cleared", 64'(bus.error), 64'd0);
        wait_done(d0, 400);

        // Zero-length job.
        d0 = done_cnt;
        r0 = req_total;
        pulse_start(20'h00040, 0);
        @(negedge clk);
        chk("zero_done", 64'(bus.done), 64'd1);
        chk("zero_busy", 64'(bus.busy), 64'd0);
        repeat (10) @(negedge clk);
        chk("zero_no_req", 64'(req_total - r0), 64'd0);
        chk("zero_done_once", 64'(done_cnt), 64'(d0 + 1));

        // Back-to-back start the cycle after done, crossing the address wrap.
        run_job(20'hFFFFE, 1);
        chk("wrap_final_addr", 64'(bus.fmc_addr), 64'h00002);

        // Reset mid-job during WAIT_DATA of byte 5.
        resp_delay = 6;
        resp_seen = 0;
        r0 = req_total;
        expect_job(20'h07770, 3);
        pulse_start(20'h07770, 3);
        wait_resp(5, 200);
        @(posedge clk);
        #2;
        gen++;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_req", 64'(bus.fmc_req), 64'd0);
        chk("mid_rst_addr", 64'(bus.fmc_addr), 64'd0);
        chk("mid_rst_wvalid", 64'(bus.word_valid), 64'd0);
        exp_words.delete();
        exp_addr.delete();
        @(posedge clk);
        #1 n_rst = 1'b1;
        r0 = req_total;
        bus.fmc_data_valid = 1'b1;
        bus.fmc_data = 8'h5C;
        @(posedge clk);
        #1 bus.fmc_data_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_valid_no_word", 64'(bus.word_valid), 64'd0);
        chk("late_valid_no_req", 64'(req_total - r0), 64'd0);
        resp_delay = 3;

        // Spurious fmc_data_valid in IDLE and start while busy.
        a0 = bus.fmc_addr;
        r0 = req_total;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 bus.fmc_data_valid = 1'b1;
            bus.fmc_data = 8'(i + 1);
            @(posedge clk);
            #1 bus.fmc_data_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("spur_addr", 64'(bus.fmc_addr), 64'(a0));
        chk("spur_wvalid", 64'(bus.word_valid), 64'd0);
        chk("spur_no_req", 64'(req_total - r0), 64'd0);
        d0 = done_cnt;
        resp_seen = 0;
        expect_job(20'h0ABC4, 2);
        pulse_start(20'h0ABC4, 2);
        wait_resp(2, 100);
        pulse_start(20'h55555, 7);
        wait_done(d0, 400);

        // Randomized jobs with random response delay and consumer stalls.
        resp_delay = 0;
        ready_rand = 1;
        for (int j = 0; j < 5; j++) begin
            run_job(AW'($urandom), int'($urandom_range(1, 5)));
        end
        ready_rand = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
